// File: rtl/mul_core_pkg.sv
// rtl/mul_core_pkg.sv - shared widths, cycle counts, state encoding and popcount helper
package mul_core_pkg;

    localparam int A_W               = 24;
    localparam int W_W               = 32;
    localparam int P_W               = 2 * A_W;
    localparam int L_W               = 24;
    localparam int CNT_W             = 16;
    localparam int MULT_CYCLES       = 24;
    localparam int COUNT_CYCLES      = 8;
    localparam int NIBBLES_PER_CYCLE = 1;
    localparam int NIB_W             = 4 * NIBBLES_PER_CYCLE;
    localparam int POP_W             = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MULT  = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [POP_W-1:0] popcnt_nib(input logic [NIB_W-1:0] bits);
        logic [POP_W-1:0] s;
        s = '0;
        for (int i = 0; i < NIB_W; i++) begin
            s = s + {{(POP_W-1){1'b0}}, bits[i]};
        end
        return s;
    endfunction

endpackage

// File: rtl/mul_popcnt_core_mul.sv
// rtl/mul_popcnt_core_mul.sv - 24x24 shift-add multiplier, one multiplier bit per step
//
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   load       - capture a/b, clear accumulator and cycle counter
//   step       - perform one shift-add iteration (LSB of multiplier first)
//   a, b       - multiplicand / multiplier
//   last       - high while the current step is the final (24th) one
//   product    - accumulator; exact 48-bit product once the last step is taken
module shift_add_mul24
    import mul_core_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           step,
    input  logic [A_W-1:0] a,
    input  logic [A_W-1:0] b,
    output logic           last,
    output logic [P_W-1:0] product
);

    logic [P_W-1:0] mcand_q, mcand_d;
    logic [A_W-1:0] mplier_q, mplier_d;
    logic [P_W-1:0] acc_q, acc_d;
    logic [4:0]     cyc_q, cyc_d;

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cyc_d    = cyc_q;
        if (load) begin
            mcand_d  = {{(P_W-A_W){1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cyc_d    = '0;
        end else if (step) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cyc_d    = cyc_q + 5'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cyc_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cyc_q    <= cyc_d;
        end
    end

    assign last    = (cyc_q == 5'(MULT_CYCLES - 1));
    assign product = acc_q;

endmodule

// File: rtl/mul_popcnt_core.sv
// rtl/mul_popcnt_core.sv - sequential multiply + popcount engine behind the GPIO register block
//
// Ports:
//   clk, reset      - clock, asynchronous active-high reset
//   start, a1, a2   - one-cycle request with operands, accepted only when ready
//   ready, busy     - IDLE / non-IDLE indication
//   done            - one-cycle pulse while in DONE (results already valid)
//   w, l, valid     - product[31:0], popcount(product[31:0]), no overflow past w
//   status          - {ready, valid}
//   op_count        - completed-operation counter, wraps
module mul_popcnt_core
    import mul_core_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [A_W-1:0]   a1,
    input  logic [A_W-1:0]   a2,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [W_W-1:0]   w,
    output logic [L_W-1:0]   l,
    output logic             valid,
    output logic [1:0]       status,
    output logic [CNT_W-1:0] op_count
);

    state_t           state_q, state_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [W_W-1:0]   w_q, w_d;
    logic [L_W-1:0]   l_q, l_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;
    logic [POP_W-1:0] pop_q, pop_d;
    logic [2:0]       nib_q, nib_d;

    logic             mul_load;
    logic             mul_step;
    logic             mul_last;
    logic [P_W-1:0]   product;
    logic [POP_W-1:0] pop_sum;

    shift_add_mul24 u_mul (
        .clk     (clk),
        .rst     (reset),
        .load    (mul_load),
        .step    (mul_step),
        .a       (a1),
        .b       (a2),
        .last    (mul_last),
        .product (product)
    );

    // Running count including the nibble scanned this cycle, so the final
    // value can be registered into l on the same edge that enters DONE.
    assign pop_sum = pop_q + popcnt_nib(product[32'(nib_q) * NIB_W +: NIB_W]);

    always_comb begin
        state_d    = state_q;
        w_d        = w_q;
        l_d        = l_q;
        valid_d    = valid_q;
        op_count_d = op_count_q;
        pop_d      = pop_q;
        nib_d      = nib_q;
        mul_load   = 1'b0;
        mul_step   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (a1 == '0 || a2 == '0) begin
                        // Zero operand: product is known, skip the loop.
                        state_d = DONE;
                        w_d     = '0;
                        l_d     = '0;
                        valid_d = 1'b1;
                    end else begin
                        state_d  = MULT;
                        mul_load = 1'b1;
                    end
                end
            end
            MULT: begin
                mul_step = 1'b1;
                if (mul_last) begin
                    state_d = COUNT;
                    pop_d   = '0;
                    nib_d   = '0;
                end
            end
            COUNT: begin
                pop_d = pop_sum;
                nib_d = nib_q + 3'd1;
                if (nib_q == 3'(COUNT_CYCLES - 1)) begin
                    state_d = DONE;
                    w_d     = product[W_W-1:0];
                    l_d     = {{(L_W-POP_W){1'b0}}, pop_sum};
                    valid_d = ~|product[P_W-1:W_W];
                end
            end
            DONE: begin
                state_d    = IDLE;
                op_count_d = op_count_q + CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            w_q        <= '0;
            l_q        <= '0;
            valid_q    <= 1'b1;
            op_count_q <= '0;
            pop_q      <= '0;
            nib_q      <= '0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            w_q        <= w_d;
            l_q        <= l_d;
            valid_q    <= valid_d;
            op_count_q <= op_count_d;
            pop_q      <= pop_d;
            nib_q      <= nib_d;
        end
    end

    assign ready    = ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign w        = w_q;
    assign l        = l_q;
    assign valid    = valid_q;
    assign status   = {ready_q, valid_q};
    assign op_count = op_count_q;

endmodule
